rx_detection_fifo: RTL

- Sits directly downstream of the receiver top level.
- Captures each detection event (peak value, sequence ID, timestamp) on the detection trigger and buffers it in a small FIFO for ARM-side readout.
- Adds a re-trigger holdoff, an event index tag, overflow accounting and a level interrupt, so software can drain detections asynchronously without losing track of dropped events.

---
 rtl/rx_detection_fifo.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rx_detection_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_detection_fifo
// Purpose  : Captures receiver detection events (peak, sequence ID, timestamp)
//            into a small FIFO for ARM readout. Adds a re-trigger holdoff, an
//            event index tag, overflow/drop accounting and a level interrupt.
// Ports    : crx_clk / rrx_rst_n      clock, async active-low reset
//            erx_en                   capture enable
//            isample_peak, ireceived_seq, itime, itrigger   detection input
//            ird_req, iclear_ovf      ARM read request, overflow clear
//            o_rd_*                   popped entry (1-clock read latency)
//            o_rd_err                 read requested while empty
//            o_level, o_overflow, o_drop_cnt, o_irq   status
// Revision : 1.0  initial release
// ============================================================================
module rx_detection_fifo #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int HOLDOFF   = 64,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                crx_clk,
    input  logic                rrx_rst_n,
    input  logic                erx_en,
    input  logic signed [40:0]  isample_peak,
    input  logic [3:0]          ireceived_seq,
    input  logic [15:0]         itime,
    input  logic                itrigger,
    input  logic                ird_req,
    input  logic                iclear_ovf,
    output logic                o_rd_valid,
    output logic signed [40:0]  o_rd_peak,
    output logic [3:0]          o_rd_seq,
    output logic [15:0]         o_rd_time,
    output logic [7:0]          o_rd_index,
    output logic                o_rd_err,
    output logic [ADDR_W:0]     o_level,
    output logic                o_overflow,
    output logic [7:0]          o_drop_cnt,
    output logic                o_irq
);

    localparam int              HO_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int              ENTRY_W = 69;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] C_IRQ   = (ADDR_W + 1)'(IRQ_LEVEL);
    localparam logic [HO_W-1:0] C_HOLD  = HO_W'(HOLDOFF);

    // Storage has no reset; contents are only observed after being written.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]    count_q,    count_d;
    logic [HO_W-1:0]    holdoff_q,  holdoff_d;
    logic [7:0]         evt_idx_q,  evt_idx_d;
    logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_err_q,   rd_err_d;
    logic               ovf_q,      ovf_d;
    logic [7:0]         drop_q,     drop_d;
    logic               irq_q,      irq_d;

    logic               w_capture;
    logic               w_rd_accept;
    logic               w_wr_en;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_entry;

    always_comb begin
        w_capture   = itrigger && erx_en && (holdoff_q == '0);
        // Read decision uses the count before any same-cycle write, so an
        // empty FIFO never falls through a simultaneous capture.
        w_rd_accept = ird_req && (count_q != '0);
        // A full FIFO still accepts a capture when a read frees a slot.
        w_wr_en     = w_capture && ((count_q < C_DEPTH) || w_rd_accept);
        w_drop      = w_capture && !w_wr_en;
        w_entry     = {evt_idx_q, isample_peak, ireceived_seq, itime};

        wr_ptr_d    = w_wr_en     ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = w_rd_accept ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_entry_d  = w_rd_accept ? mem_q[rd_ptr_q] : rd_entry_q;
        rd_valid_d  = w_rd_accept;
        rd_err_d    = ird_req && (count_q == '0);

        count_d = count_q;
        case ({w_wr_en, w_rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (!erx_en) begin
            holdoff_d = '0;
        end else if (w_capture) begin
            holdoff_d = C_HOLD;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end else begin
            holdoff_d = holdoff_q;
        end

        // Dropped events consume an index too, so gaps reveal lost events.
        evt_idx_d = w_capture ? evt_idx_q + 8'd1 : evt_idx_q;

        // A drop in the same cycle as a clear wins and restarts the count at 1.
        if (w_drop) begin
            ovf_d  = 1'b1;
            drop_d = iclear_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end else if (iclear_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end

        irq_d = (count_d >= C_IRQ);
    end

    always_ff @(posedge crx_clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            holdoff_q  <= '0;
            evt_idx_q  <= '0;
            rd_entry_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            holdoff_q  <= holdoff_d;
            evt_idx_q  <= evt_idx_d;
            rd_entry_q <= rd_entry_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            irq_q      <= irq_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_index = rd_entry_q[68:61];
    assign o_rd_peak  = rd_entry_q[60:20];
    assign o_rd_seq   = rd_entry_q[19:16];
    assign o_rd_time  = rd_entry_q[15:0];
    assign o_rd_err   = rd_err_q;
    assign o_level    = count_q;
    assign o_overflow = ovf_q;
    assign o_drop_cnt = drop_q;
    assign o_irq      = irq_q;

endmodule
`default_nettype wire
